// File: rtl/drain_pkg.sv
// Shared constants and types for the drain scheduler.
//   N      : output word width
//   W_E/C/P: field width shifted out of each source register per grant
//   ACC_W  : accumulator width, wide enough for a nearly full word plus one widest field
//   FILL_W : width of the accumulator fill counter
package drain_pkg;
  localparam int N      = 64;
  localparam int W_E    = 24;
  localparam int W_C    = 15;
  localparam int W_P    = 9;
  localparam int CNT_W  = 11;
  localparam int W_MAX  = 24;
  localparam int ACC_W  = N + W_MAX;
  localparam int FILL_W = 7;

  typedef enum logic [1:0] {
    SRC_E = 2'd0,
    SRC_C = 2'd1,
    SRC_P = 2'd2
  } src_t;
endpackage

// File: rtl/drain_scheduler_if.sv
// Output word handshake bundle.
//   out_data  : packed output word (master -> slave)
//   out_valid : out_data valid       (master -> slave)
//   out_ready : slave accepts word   (slave -> master)
interface drain_scheduler_if;
  import drain_pkg::*;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rr_arb3.sv
// Three-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-low reset
//   req[2:0] : request per source (bit 0 = E, 1 = C, 2 = P)
//   advance  : allow the pointer to move onto the granted source
//   grant    : one-hot grant, search starts after the last granted source
module rr_arb3
  import drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);
  src_t ptr_reg;

  always_comb begin
    grant = 3'b000;
    case (ptr_reg)
      SRC_E: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      SRC_C: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  // Reset to P so that E is searched first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= SRC_P;
    end else if (advance && (|grant)) begin
      ptr_reg <= grant[0] ? SRC_E : (grant[1] ? SRC_C : SRC_P);
    end
  end
endmodule

// File: rtl/drain_scheduler.sv
// Shares one output word path between the E, C and P field shift registers.
// Grants one-cycle shifts round-robin to registers holding a full field, packs
// the granted fields MSB-first into an accumulator and emits N-bit words.
//   clk, rst            : clock, asynchronous active-low reset
//   enable              : allow grants
//   flush               : pulse, emit any partial word zero-padded
//   count_*/field_*     : bit count and head field of each source register
//   shift_*             : one-cycle grant pulse to each source register
//   dout                : output word valid/ready handshake
//   fill                : bits currently held in the accumulator
//   flush_done          : pulse when a flush has completed
module drain_scheduler
  import drain_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic [CNT_W-1:0]    count_e,
  input  logic [CNT_W-1:0]    count_c,
  input  logic [CNT_W-1:0]    count_p,
  input  logic [W_E-1:0]      field_e,
  input  logic [W_C-1:0]      field_c,
  input  logic [W_P-1:0]      field_p,
  output logic                shift_e,
  output logic                shift_c,
  output logic                shift_p,
  drain_scheduler_if.master   dout,
  output logic [FILL_W-1:0]   fill,
  output logic                flush_done
);
  logic [ACC_W-1:0]  acc_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [N-1:0]      data_reg;
  logic              valid_reg;
  logic              pend_reg;
  logic              done_reg;

  logic              below_n;
  logic              xfer;
  logic              any_grant;
  logic [2:0]        req;
  logic [2:0]        arb_grant;
  logic [2:0]        grant;
  logic [ACC_W-1:0]  ins_field;
  logic [FILL_W-1:0] ins_w;

  assign below_n = fill_reg < FILL_W'(N);

  assign req[0] = enable && !pend_reg && below_n && (count_e >= CNT_W'(W_E));
  assign req[1] = enable && !pend_reg && below_n && (count_c >= CNT_W'(W_C));
  assign req[2] = enable && !pend_reg && below_n && (count_p >= CNT_W'(W_P));

  rr_arb3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (1'b1),
    .grant   (arb_grant)
  );

  // Count inputs may look eligible while reset is held; keep shifts quiet.
  assign grant     = arb_grant & {3{rst}};
  assign any_grant = |grant;
  assign shift_e   = grant[0];
  assign shift_c   = grant[1];
  assign shift_p   = grant[2];

  // Granted field left-aligned in accumulator width; shifted right by fill on capture.
  always_comb begin
    ins_field = '0;
    ins_w     = '0;
    if (grant[0]) begin
      ins_field = {field_e, {(ACC_W-W_E){1'b0}}};
      ins_w     = FILL_W'(W_E);
    end else if (grant[1]) begin
      ins_field = {field_c, {(ACC_W-W_C){1'b0}}};
      ins_w     = FILL_W'(W_C);
    end else if (grant[2]) begin
      ins_field = {field_p, {(ACC_W-W_P){1'b0}}};
      ins_w     = FILL_W'(W_P);
    end
  end

  assign xfer = !below_n && (!valid_reg || dout.out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      fill_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      pend_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Capture and transfer never coincide: capture needs fill < N.
      if (any_grant) begin
        acc_reg  <= acc_reg | (ins_field >> fill_reg);
        fill_reg <= fill_reg + ins_w;
      end

      if (xfer) begin
        data_reg  <= acc_reg[ACC_W-1 -: N];
        acc_reg   <= acc_reg << N;
        fill_reg  <= fill_reg - FILL_W'(N);
        valid_reg <= 1'b1;
        // Last bits of a pending flush leave with this word.
        if (pend_reg && (fill_reg == FILL_W'(N))) begin
          done_reg <= 1'b1;
          pend_reg <= 1'b0;
        end
      end else if (valid_reg && dout.out_ready) begin
        valid_reg <= 1'b0;
      end

      // Accumulator bits below fill are already zero, so padding is only a fill bump.
      if (pend_reg && (fill_reg != '0) && below_n) begin
        fill_reg <= FILL_W'(N);
      end

      if (pend_reg && (fill_reg == '0)) begin
        done_reg <= 1'b1;
        pend_reg <= 1'b0;
      end

      if (flush && !pend_reg) begin
        if ((fill_reg == '0) && !any_grant) done_reg <= 1'b1;
        else                                pend_reg <= 1'b1;
      end
    end
  end

  assign dout.out_data  = data_reg;
  assign dout.out_valid = valid_reg;
  assign fill           = fill_reg;
  assign flush_done     = done_reg;
endmodule

// File: tb/tb_drain_scheduler.sv
// Bench for drain_scheduler: source registers modelled as field queues, and a
// reference model holding the accumulator as a bit queue.
module tb_drain_scheduler;
  import drain_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  count_e, count_c, count_p;
  logic [W_E-1:0]    field_e;
  logic [W_C-1:0]    field_c;
  logic [W_P-1:0]    field_p;
  logic              shift_e, shift_c, shift_p;
  logic [FILL_W-1:0] fill;
  logic              flush_done;

  drain_scheduler_if dout_if();

  always #5 clk = ~clk;

  drain_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .count_e    (count_e),
    .count_c    (count_c),
    .count_p    (count_p),
    .field_e    (field_e),
    .field_c    (field_c),
    .field_p    (field_p),
    .shift_e    (shift_e),
    .shift_c    (shift_c),
    .shift_p    (shift_p),
    .dout       (dout_if),
    .fill       (fill),
    .flush_done (flush_done)
  );

  int total = 0;
  int bad   = 0;

  // Source registers
  logic [23:0] qe[$];
  logic [14:0] qc[$];
  logic [8:0]  qp[$];

  // Reference model
  bit          m_acc[$];
  int          m_fill;
  logic        m_ov;
  logic [63:0] m_od;
  logic        m_fp;
  logic        m_fd;
  int          m_ptr;

  logic [63:0] got_words[$];
  bit          saw_done_valid;
  bit          saw_done;
  int          widths[3] = '{24, 15, 9};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] capc(input int v);
    return (v > 2047) ? CNT_W'(2047) : CNT_W'(v);
  endfunction

  task automatic set_env();
    count_e = capc(qe.size() * 24);
    count_c = capc(qc.size() * 15);
    count_p = capc(qp.size() * 9);
    field_e = (qe.size() > 0) ? qe[0] : '0;
    field_c = (qc.size() > 0) ? qc[0] : '0;
    field_p = (qp.size() > 0) ? qp[0] : '0;
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_fill = 0; m_ov = 0; m_od = '0; m_fp = 0; m_fd = 0; m_ptr = 2;
  endtask

  function automatic logic [2:0] pred_grant();
    int cnt[3];
    cnt[0] = int'(count_e); cnt[1] = int'(count_c); cnt[2] = int'(count_p);
    if (enable && !m_fp && m_fill < 64) begin
      for (int k = 1; k <= 3; k++) begin
        int idx = (m_ptr + k) % 3;
        if (cnt[idx] >= widths[idx]) return 3'(1 << idx);
      end
    end
    return 3'b000;
  endfunction

  task automatic model_update(input logic [2:0] g, input logic rdy, input logic fl);
    int   f0  = m_fill;
    logic fp0 = m_fp;
    logic ov0 = m_ov;
    m_fd = 0;
    if (g[0]) begin for (int b = 23; b >= 0; b--) m_acc.push_back(field_e[b]); m_ptr = 0; end
    if (g[1]) begin for (int b = 14; b >= 0; b--) m_acc.push_back(field_c[b]); m_ptr = 1; end
    if (g[2]) begin for (int b = 8;  b >= 0; b--) m_acc.push_back(field_p[b]); m_ptr = 2; end
    if (f0 >= 64 && (!ov0 || rdy)) begin
      for (int b = 63; b >= 0; b--) m_od[b] = m_acc.pop_front();
      m_ov = 1;
      if (fp0 && f0 == 64) begin m_fd = 1; m_fp = 0; end
    end else if (ov0 && rdy) begin
      m_ov = 0;
    end
    if (fp0 && f0 > 0 && f0 < 64) begin
      while (m_acc.size() < 64) m_acc.push_back(1'b0);
    end
    if (fp0 && f0 == 0) begin m_fd = 1; m_fp = 0; end
    if (fl && !fp0) begin
      if (f0 == 0 && g == 3'b000) m_fd = 1;
      else                        m_fp = 1;
    end
    m_fill = m_acc.size();
  endtask

  // Called at posedge+1 with stimulus set; returns at the next posedge+1.
  task automatic step();
    logic [2:0] eg;
    logic [2:0] sh;
    logic       rdy;
    logic       fl;
    set_env();
    #1;
    eg = pred_grant();
    sh = {shift_p, shift_c, shift_e};
    chk("shift",      {61'd0, sh},                eg);
    chk("fill",       {57'd0, fill},              64'(m_fill));
    chk("out_valid",  {63'd0, dout_if.out_valid}, {63'd0, m_ov});
    chk("out_data",   dout_if.out_data,           m_od);
    chk("flush_done", {63'd0, flush_done},        {63'd0, m_fd});
    if (flush_done && dout_if.out_valid) saw_done_valid = 1;
    if (flush_done) saw_done = 1;
    rdy = dout_if.out_ready;
    fl  = flush;
    if (dout_if.out_valid && rdy) begin
      got_words.push_back(dout_if.out_data);
      $display("word %0d data=%h fill=%0d", got_words.size(), dout_if.out_data, fill);
    end
    @(posedge clk);
    model_update(eg, rdy, fl);
    if (sh[0] && qe.size() > 0) void'(qe.pop_front());
    if (sh[1] && qc.size() > 0) void'(qc.pop_front());
    if (sh[2] && qp.size() > 0) void'(qp.pop_front());
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_flush();
    flush = 1; step(); flush = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_shift", {61'd0, shift_p, shift_c, shift_e}, 64'd0);
    chk("rst_valid", {63'd0, dout_if.out_valid},         64'd0);
    chk("rst_fill",  {57'd0, fill},                      64'd0);
    chk("rst_data",  dout_if.out_data,                   64'd0);
    chk("rst_done",  {63'd0, flush_done},                64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    logic [23:0] e0, e1;
    logic [14:0] c0;
    logic [8:0]  p0;
    int          n0;
    dout_if.out_ready = 1'b1;
    set_env();
    do_reset();
    enable = 1;

    // Two E fields then flush: padded word, flush_done with out_valid.
    qe.push_back(24'hABCDEF); qe.push_back(24'h123456);
    got_words.delete(); saw_done_valid = 0;
    run(6);
    chk("e_only_fill", {57'd0, fill}, 64'd48);
    pulse_flush();
    run(6);
    chk("e_flush_word", (got_words.size() > 0) ? got_words[0] : 64'hx, 64'hABCDEF123456_0000);
    chk("e_flush_done_with_valid", {63'd0, saw_done_valid}, 64'd1);

    // All sources busy: first word E|C|P|E[23:8], then backpressure.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      qe.push_back(24'($urandom())); qc.push_back(15'($urandom())); qp.push_back(9'($urandom()));
    end
    e0 = qe[0]; e1 = qe[1]; c0 = qc[0]; p0 = qp[0];
    got_words.delete();
    run(8);
    chk("rr_first_word", (got_words.size() > 0) ? got_words[0] : 64'hx, {e0, c0, p0, e1[23:8]});
    dout_if.out_ready = 0;
    run(15);
    dout_if.out_ready = 1;
    run(20);

    // P only, all ones: eight grants give one all-ones word with 8 left over.
    do_reset();
    qe.delete(); qc.delete(); qp.delete();
    for (int i = 0; i < 8; i++) qp.push_back(9'h1FF);
    got_words.delete();
    run(12);
    chk("p_word", (got_words.size() > 0) ? got_words[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p_fill", {57'd0, fill}, 64'd8);
    pulse_flush();
    run(6);

    // Flush with an empty accumulator: done next cycle, no word.
    n0 = got_words.size(); saw_done = 0;
    pulse_flush();
    step();
    chk("empty_flush_done", {63'd0, saw_done}, 64'd1);
    chk("empty_flush_words", 64'(got_words.size()), 64'(n0));

    // Randomised traffic: refills, backpressure, enable drops, flushes.
    for (int i = 0; i < 1500; i++) begin
      if (qe.size() < 4 && $urandom_range(0, 3) == 0) qe.push_back(24'($urandom()));
      if (qc.size() < 4 && $urandom_range(0, 3) == 0) qc.push_back(15'($urandom()));
      if (qp.size() < 4 && $urandom_range(0, 3) == 0) qp.push_back(9'($urandom()));
      dout_if.out_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 15) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
      flush = 0;
    end

    // Reset mid-word with a stalled output word, then E wins first.
    enable = 1; dout_if.out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      qe.push_back(24'($urandom())); qc.push_back(15'($urandom())); qp.push_back(9'($urandom()));
    end
    run(12);
    chk("pre_rst_valid", {63'd0, dout_if.out_valid}, 64'd1);
    do_reset();
    dout_if.out_ready = 1;
    set_env();
    #1;
    chk("post_rst_first_grant", {61'd0, shift_p, shift_c, shift_e}, 64'd1);
    #1;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drain_scheduler.md
Name: drain_scheduler

Overview:
Shares the single output word path between the three field shift registers (E, C, P). Round-robin grants a one-cycle shift to any register holding at least one full field, and packs granted fields MSB-first into an accumulator. Emits N-bit words over a valid/ready handshake, with flush/zero-padding for partial words. Sits between the reg_e/reg_c/reg_p instances and the system output, replacing ad-hoc shift sequencing in the controller.

Parameters:
N, 64, output word width
W_E, 24, reg_e field width (bits per shift)
W_C, 15, reg_c field width
W_P, 9, reg_p field width
CNT_W, 11, width of register bit-count inputs
ACC_W, N+24, accumulator width (derived; must be >= N + max(W_*) - 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (rst=0 resets)
enable  in  1  grants allowed when 1
flush  in  1  one-cycle pulse: emit any partial word zero-padded
count_e / count_c / count_p  in  CNT_W  valid bits held in each register
field_e / field_c / field_p  in  W_E / W_C / W_P  current head field of each register
shift_e / shift_c / shift_p  out  1  one-cycle shift pulse (grant)
out_data  out  N  packed output word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
fill  out  7  bits currently in accumulator (0..ACC_W-1)
flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset (rst low, async): acc=0, fill=0, out_data=0, out_valid=0, flush_pending=0, flush_done=0, rr pointer=P (E highest priority first). shift_* forced 0 while rst low.
- Eligibility: req_r = enable & !flush_pending & (count_r >= W_r) & (fill < N).
- Grant: combinational from registered state + count inputs; at most one shift_* high per cycle. Round-robin order E->C->P->E, search starts after last granted; pointer updates only on grant.
- Capture: on grant edge, field_r is written into acc at bit positions [ACC_W-1-fill -: W_r]; fill += W_r. The register advances on the same edge; next cycle count_r is already reduced.
- Transfer: when fill >= N and (!out_valid or out_ready): out_data <= acc[ACC_W-1 -: N], acc <<= N (zero fill), fill -= N, out_valid <= 1. Else if out_valid & out_ready: out_valid <= 0. out_data holds stable while out_valid & !out_ready.
- Grant and transfer are mutually exclusive (grant needs fill<N, transfer needs fill>=N); fill never exceeds N+23.
- Latency: grant of field completing a word -> out_valid high 1 cycle later (if output register free).
- Flush: pulse sets flush_pending (grants blocked from next cycle; a grant in the pulse cycle still completes). Pending and 0<fill<N: fill <= N (padding is zero bits already present), then normal transfer. flush_done pulses in the cycle the padded word's out_valid rises. fill==0 (and no grant in pulse cycle): flush_done next cycle, no word. flush_pending clears with flush_done. Flush while pending: ignored.
- Backpressure: out_ready low with fill>=N stalls all grants; no data loss.
- Reset mid-operation discards accumulator and pending output word.
- enable low: no grants; transfers and flush proceed.

Decomposition:
- Package drain_pkg: field-width constants W_E/W_C/W_P, ACC_W, source index enum {SRC_E, SRC_C, SRC_P}.
- Sub-module rr_arb3: 3-requester round-robin arbiter (req[2:0], advance -> one-hot grant, pointer state); the rest is top-level.

Test Plan:
- Only count_e=48, field_e=24'hABCDEF then 24'h123456, out_ready=1 -> two shift_e pulses, fill 24->48, no output until more data; then flush -> out_data=64'hABCDEF123456_0000, flush_done same cycle as out_valid.
- count_e/c/p all >= width, out_ready=1 -> grant order E,C,P,E,C,P...; first word = E24|C15|P9|E16 (MSB-first), 8 leftover bits carried, fill=8.
- Hold out_ready=0 after first word -> out_valid stays 1, out_data constant, shift_* stop once fill>=64; release -> word accepted, grants resume next cycle.
- Only count_p=9 repeated, field_p=9'h1FF -> 7 grants give fill=63, 8th gives 72 -> out_data=64'hFFFF_FFFF_FFFF_FFFF, fill=8.
- flush with fill=0 -> flush_done 1 cycle later, out_valid stays 0.
- Assert rst low mid-word (fill=40, out_valid=1) -> out_valid=0, fill=0, shift_*=0 immediately; after release first grant goes to E.
